// File: rtl/reg_file.sv
// 14 x 8-bit register file: shared address, synchronous write, combinational read, parallel taps.
// Optional write-first forwarding on rf_reg_out is enabled by defining RF_WRITE_BYPASS_EN.
module reg_file #(
  parameter int unsigned NUM_REGS = 14,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rf_write_reg,
  input  logic [ADDR_W-1:0] rf_reg_in,
  input  logic [DATA_W-1:0] rf_write_data,
  output logic [DATA_W-1:0] rf_reg_out,
  output logic [DATA_W-1:0] rs [NUM_REGS-1:0]
);

  // Declaration initialiser gives the zero power-on state before any edge.
  logic [DATA_W-1:0] regs_q [NUM_REGS-1:0] = '{default: '0};
  logic              addr_ok;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;

  assign addr_ok = (32'(rf_reg_in) < NUM_REGS);
  assign wr_en   = rf_write_reg && addr_ok;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        regs_q[i] <= '0;
      end else if (wr_en && (ADDR_W'(i) == rf_reg_in)) begin
        regs_q[i] <= rf_write_data;
      end
    end
  end

  // Out-of-range addresses match no entry, so the read falls back to zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ADDR_W'(i) == rf_reg_in) begin
        rd_data = regs_q[i];
      end
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  always_comb begin
    rf_reg_out = rd_data;
    if (wr_en && !rst) begin
      rf_reg_out = rf_write_data;
    end
  end
`else
  assign rf_reg_out = rd_data;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      rs[i] = regs_q[i];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed, table-driven bench for reg_file with hand-computed read-back values.
module tb_reg_file;

  localparam int unsigned NR = 14;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = 4'd0;
  logic [7:0] wdata = 8'd0;
  logic [7:0] rout;
  logic [7:0] rs [NR-1:0];

  logic [7:0] model [NR];
  int checks = 0;
  int errors = 0;

  reg_file #(.NUM_REGS(14), .DATA_W(8), .ADDR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rf_write_reg (we),
    .rf_reg_in    (addr),
    .rf_write_data(wdata),
    .rf_reg_out   (rout),
    .rs           (rs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] exp_out;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all_rs(input string tag);
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s rs[%0d]", tag, i), rs[i], model[i]);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rst; we = v.we; addr = v.addr; wdata = v.data;
    @(posedge clk);
    if (v.rst) begin
      for (int i = 0; i < NR; i++) model[i] = 8'h00;
    end else if (v.we && v.addr < 4'd14) begin
      model[v.addr] = v.data;
    end
    #1;
  endtask

  vec_t vecs [12];

  initial begin
    for (int i = 0; i < NR; i++) model[i] = 8'h00;
    vecs[0]  = '{1'b0, 1'b1, 4'd7,  8'h02, 8'h02};
    vecs[1]  = '{1'b0, 1'b1, 4'd13, 8'h4A, 8'h4A};
    vecs[2]  = '{1'b0, 1'b0, 4'd7,  8'h55, 8'h02};
    vecs[3]  = '{1'b0, 1'b1, 4'd15, 8'hFF, 8'h00};
    vecs[4]  = '{1'b0, 1'b1, 4'd14, 8'h11, 8'h00};
    vecs[5]  = '{1'b0, 1'b1, 4'd0,  8'h81, 8'h81};
    vecs[6]  = '{1'b0, 1'b1, 4'd13, 8'hC3, 8'hC3};
    vecs[7]  = '{1'b0, 1'b0, 4'd13, 8'h00, 8'hC3};
    vecs[8]  = '{1'b0, 1'b0, 4'd6,  8'h77, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 4'd3,  8'hAA, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 4'd7,  8'h00, 8'h00};
    vecs[11] = '{1'b0, 1'b0, 4'd13, 8'h00, 8'h00};

    // Power-up state before the first edge.
    #1;
    chk("powerup out", rout, 8'h00);
    chk_all_rs("powerup");

    for (int k = 0; k < 12; k++) begin
      apply(vecs[k]);
      chk($sformatf("vec%0d out", k), rout, vecs[k].exp_out);
      chk_all_rs($sformatf("vec%0d", k));
    end

    // Write r7 then read other addresses without any clock edge.
    apply('{1'b0, 1'b1, 4'd7, 8'h02, 8'h02});
    we = 1'b0; addr = 4'd13; #1;
    chk("comb read r13", rout, 8'h00);
    addr = 4'd7; #1;
    chk("comb read r7", rout, 8'h02);
    addr = 4'd15; #1;
    chk("comb read oor", rout, 8'h00);

    // Idle clocks leave state untouched.
    addr = 4'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("idle r7 out", rout, 8'h02);
    chk_all_rs("idle");

    // Read during write to the same address, before and after the edge.
    @(negedge clk);
    we = 1'b1; addr = 4'd7; wdata = 8'h99; #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("rdw pre-edge out", rout, 8'h99);
`else
    chk("rdw pre-edge out", rout, 8'h02);
`endif
    chk("rdw pre-edge rs7", rs[7], 8'h02);
    @(posedge clk);
    model[7] = 8'h99;
    #1;
    chk("rdw post-edge out", rout, 8'h99);
    chk("rdw post-edge rs7", rs[7], 8'h99);

    // Forwarding check against an untouched register.
    @(negedge clk);
    we = 1'b1; addr = 4'd2; wdata = 8'h33; #1;
`ifdef RF_WRITE_BYPASS_EN
    chk("bypass r2 out", rout, 8'h33);
`else
    chk("bypass r2 out", rout, 8'h00);
`endif
    chk("bypass r2 rs", rs[2], 8'h00);
    @(negedge clk);
    we = 1'b0;
    model[2] = 8'h33;
    #1;
    chk_all_rs("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
